// File: rtl/lc2k_pkg.sv
// Shared encodings for the LC2K multi-cycle control unit: opcodes, FSM states and the
// pc_src / wb_sel / alu_op select codes driven onto the datapath muxes.
package lc2k_pkg;

    // Opcodes as they appear in mem_rdata[24:22]
    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpNor  = 3'd1;
    localparam logic [2:0] OpLw   = 3'd2;
    localparam logic [2:0] OpSw   = 3'd3;
    localparam logic [2:0] OpBeq  = 3'd4;
    localparam logic [2:0] OpJalr = 3'd5;
    localparam logic [2:0] OpHalt = 3'd6;
    localparam logic [2:0] OpNoop = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalted,
        StFault
    } state_e;

    localparam logic [1:0] PcSrcInc    = 2'b00;  // pc+1
    localparam logic [1:0] PcSrcBranch = 2'b01;  // pc+1+offset
    localparam logic [1:0] PcSrcRegA   = 2'b10;  // regA (JALR)

    localparam logic [1:0] WbSelAlu = 2'b00;
    localparam logic [1:0] WbSelMem = 2'b01;
    localparam logic [1:0] WbSelPc  = 2'b10;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluNor = 2'b01;
    localparam logic [1:0] AluEq  = 2'b10;

    // States that own the shared memory port
    function automatic logic is_mem_state(state_e s);
        return (s == StFetch) || (s == StMem);
    endfunction

endpackage

// File: rtl/lc2k_multicycle_ctrl_if.sv
// Control-unit <-> datapath/memory bundle. master = control unit, slave = datapath side.
// Optional macro LC2K_PERF_CNT_EN adds the retired/cycles performance counter signals.
interface lc2k_multicycle_ctrl_if #(
    parameter int unsigned ALU_OP_W = 2
`ifdef LC2K_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
);
    logic                mem_ready;
    logic [2:0]          mem_opcode;
    logic                alu_eq;
    logic                mem_req;
    logic                mem_we;
    logic                addr_sel;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic                reg_we;
    logic                reg_dst_sel;
    logic [1:0]          wb_sel;
    logic                alu_srcb;
    logic [ALU_OP_W-1:0] alu_op;
    logic                halted;
    logic                fault;
`ifdef LC2K_PERF_CNT_EN
    logic [CNT_W-1:0]    retired;
    logic [CNT_W-1:0]    cycles;
`endif

`ifdef LC2K_PERF_CNT_EN
    modport master (
        input  mem_ready, mem_opcode, alu_eq,
        output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_we, reg_dst_sel,
               wb_sel, alu_srcb, alu_op, halted, fault, retired, cycles
    );
    modport slave (
        output mem_ready, mem_opcode, alu_eq,
        input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_we, reg_dst_sel,
               wb_sel, alu_srcb, alu_op, halted, fault, retired, cycles
    );
`else
    modport master (
        input  mem_ready, mem_opcode, alu_eq,
        output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_we, reg_dst_sel,
               wb_sel, alu_srcb, alu_op, halted, fault
    );
    modport slave (
        output mem_ready, mem_opcode, alu_eq,
        input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_we, reg_dst_sel,
               wb_sel, alu_srcb, alu_op, halted, fault
    );
`endif

endinterface

// File: rtl/lc2k_mem_watchdog.sv
// Bounded-wait watchdog for the shared memory port. Counts consecutive unanswered request
// cycles; expired_o flags the WAIT_MAX-th such cycle (a ready on that cycle still wins).
module lc2k_mem_watchdog #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic ready_i,
    output logic expired_o
);

    logic [WAIT_W-1:0] cnt_q;

    // Count waiting cycles; any transfer or leaving the memory states restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!active_i || ready_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + WAIT_W'(1);
        end
    end

    // cnt_q holds the number of earlier waiting cycles, so WAIT_MAX-1 marks the last allowed one
    always_comb begin
        expired_o = active_i && !ready_i && (cnt_q == WAIT_W'(WAIT_MAX - 1));
    end

endmodule

// File: rtl/lc2k_multicycle_ctrl.sv
// LC2K multi-cycle control unit: IDLE -> FETCH -> DECODE -> EXEC -> MEM -> WB sequencing with
// Moore strobe decode from state and latched opcode. Optional macro LC2K_PERF_CNT_EN adds the
// retired-instruction and active-cycle counters.
module lc2k_multicycle_ctrl
    import lc2k_pkg::*;
#(
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
`ifdef LC2K_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lc2k_multicycle_ctrl_if.master  bus
);

    state_e     state_q;
    logic [2:0] op_q;
    logic       wd_expired;

    lc2k_mem_watchdog #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .active_i  (is_mem_state(state_q)),
        .ready_i   (bus.mem_ready),
        .expired_o (wd_expired)
    );

    // Sequencer: state and latched opcode; HALTED/FAULT are absorbing until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpNoop;
        end else begin
            unique case (state_q)
                StIdle: state_q <= StFetch;
                StFetch: begin
                    if (bus.mem_ready) begin
                        op_q    <= bus.mem_opcode;
                        state_q <= StDecode;
                    end else if (wd_expired) begin
                        state_q <= StFault;
                    end
                end
                StDecode: begin
                    case (op_q)
                        OpHalt:  state_q <= StHalted;
                        OpNoop:  state_q <= StFetch;
                        default: state_q <= StExec;
                    endcase
                end
                StExec: begin
                    case (op_q)
                        OpAdd, OpNor: state_q <= StWb;
                        OpLw, OpSw:   state_q <= StMem;
                        default:      state_q <= StFetch;
                    endcase
                end
                StMem: begin
                    if (bus.mem_ready) begin
                        state_q <= (op_q == OpLw) ? StWb : StFetch;
                    end else if (wd_expired) begin
                        state_q <= StFault;
                    end
                end
                StWb:     state_q <= StFetch;
                StHalted: state_q <= StHalted;
                StFault:  state_q <= StFault;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Strobe decode. The only input terms are the load enables that must fire exactly on the
    // fetch handshake edge (else PC would advance every wait cycle) and the BEQ take decision.
    always_comb begin
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.addr_sel    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = PcSrcInc;
        bus.reg_we      = 1'b0;
        bus.reg_dst_sel = 1'b0;
        bus.wb_sel      = WbSelAlu;
        bus.alu_srcb    = 1'b0;
        bus.alu_op      = ALU_OP_W'(AluAdd);
        bus.halted      = 1'b0;
        bus.fault       = 1'b0;
        unique case (state_q)
            StFetch: begin
                bus.mem_req  = 1'b1;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
            end
            StExec: begin
                case (op_q)
                    OpAdd: bus.alu_srcb = 1'b1;
                    OpNor: begin
                        bus.alu_srcb = 1'b1;
                        bus.alu_op   = ALU_OP_W'(AluNor);
                    end
                    OpBeq: begin
                        bus.alu_srcb = 1'b1;
                        bus.alu_op   = ALU_OP_W'(AluEq);
                        bus.pc_write = bus.alu_eq;
                        bus.pc_src   = PcSrcBranch;
                    end
                    OpJalr: begin
                        // Datapath reads regA before the write lands, so jump uses the old value
                        bus.reg_we   = 1'b1;
                        bus.wb_sel   = WbSelPc;
                        bus.pc_write = 1'b1;
                        bus.pc_src   = PcSrcRegA;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = (op_q == OpSw);
            end
            StWb: begin
                bus.reg_we = 1'b1;
                if (op_q == OpLw) begin
                    bus.wb_sel = WbSelMem;
                end else begin
                    bus.reg_dst_sel = 1'b1;
                end
            end
            StHalted: bus.halted = 1'b1;
            StFault:  bus.fault  = 1'b1;
            default: ;
        endcase
    end

`ifdef LC2K_PERF_CNT_EN
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] cycles_q;
    logic             retire;
    logic             active;

    // Retire points: WB for ALU/LW, MEM handshake for SW, EXEC for BEQ/JALR, DECODE for NOOP/HALT
    always_comb begin
        active = (state_q != StIdle) && (state_q != StHalted) && (state_q != StFault);
        retire = (state_q == StWb) ||
                 ((state_q == StMem) && bus.mem_ready && (op_q == OpSw)) ||
                 ((state_q == StExec) && ((op_q == OpBeq) || (op_q == OpJalr))) ||
                 ((state_q == StDecode) && ((op_q == OpNoop) || (op_q == OpHalt)));
    end

    // Free-running wrap-around counters, frozen outside active states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            if (active) begin
                cycles_q <= cycles_q + CNT_W'(1);
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign bus.retired = retired_q;
    assign bus.cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Directed bench for lc2k_multicycle_ctrl. Inputs change on the falling edge, outputs are
// compared 1 time unit later; each step is one FSM state. Strobes are packed as
// {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_we, reg_dst_sel, wb_sel,
//  alu_srcb, alu_op, halted, fault}.
module tb_lc2k_multicycle_ctrl;
    import lc2k_pkg::*;

    localparam logic [15:0] VZero     = 16'b0_0_0_0_0_00_0_0_00_0_00_0_0;
    localparam logic [15:0] VFetchRdy = 16'b1_0_0_1_1_00_0_0_00_0_00_0_0;
    localparam logic [15:0] VFetchW   = 16'b1_0_0_0_0_00_0_0_00_0_00_0_0;
    localparam logic [15:0] VExAdd    = 16'b0_0_0_0_0_00_0_0_00_1_00_0_0;
    localparam logic [15:0] VExNor    = 16'b0_0_0_0_0_00_0_0_00_1_01_0_0;
    localparam logic [15:0] VExBeqT   = 16'b0_0_0_0_1_01_0_0_00_1_10_0_0;
    localparam logic [15:0] VExBeqF   = 16'b0_0_0_0_0_01_0_0_00_1_10_0_0;
    localparam logic [15:0] VExJalr   = 16'b0_0_0_0_1_10_1_0_10_0_00_0_0;
    localparam logic [15:0] VMemLw    = 16'b1_0_1_0_0_00_0_0_00_0_00_0_0;
    localparam logic [15:0] VMemSw    = 16'b1_1_1_0_0_00_0_0_00_0_00_0_0;
    localparam logic [15:0] VWbAlu    = 16'b0_0_0_0_0_00_1_1_00_0_00_0_0;
    localparam logic [15:0] VWbLw     = 16'b0_0_0_0_0_00_1_0_01_0_00_0_0;
    localparam logic [15:0] VHalted   = 16'b0_0_0_0_0_00_0_0_00_0_00_1_0;
    localparam logic [15:0] VFault    = 16'b0_0_0_0_0_00_0_0_00_0_00_0_1;

    typedef struct packed {
        logic        rdy;
        logic [2:0]  opc;
        logic        eq;
        logic [15:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    lc2k_multicycle_ctrl_if bus_if ();

    lc2k_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] strobes();
        return {bus_if.mem_req, bus_if.mem_we, bus_if.addr_sel, bus_if.ir_write,
                bus_if.pc_write, bus_if.pc_src, bus_if.reg_we, bus_if.reg_dst_sel,
                bus_if.wb_sel, bus_if.alu_srcb, bus_if.alu_op, bus_if.halted, bus_if.fault};
    endfunction

    function automatic vec_t mk(logic rdy, logic [2:0] opc, logic eq, logic [15:0] exp);
        return {rdy, opc, eq, exp};
    endfunction

    // Advance to the next state and apply that state's inputs
    task automatic next_cyc(input logic rdy, input logic [2:0] opc, input logic eq);
        @(negedge clk);
        bus_if.mem_ready  = rdy;
        bus_if.mem_opcode = opc;
        bus_if.alu_eq     = eq;
        #1;
    endtask

    // Leaves the DUT in IDLE, 1 unit after a falling edge
    task automatic do_reset();
        rst_n             = 1'b0;
        bus_if.mem_ready  = 1'b0;
        bus_if.mem_opcode = OpNoop;
        bus_if.alu_eq     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.alu_eq    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (strobes() !== VZero) begin
            $display("FAIL reset_held: got %b expected %b", strobes(), VZero);
            failures++;
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (strobes() !== VZero) begin
            $display("FAIL reset_idle: got %b expected %b", strobes(), VZero);
            failures++;
        end
        next_cyc(1'b0, OpNoop, 1'b0);
        checks++;
        if (strobes() !== VFetchW) begin
            $display("FAIL reset_first_fetch: got %b expected %b", strobes(), VFetchW);
            failures++;
        end
    endtask

    task automatic test_alu_ops();
        vec_t q[$];
        do_reset();
        q.push_back(mk(1'b1, OpAdd, 1'b0, VFetchRdy));
        q.push_back(mk(1'b1, OpAdd, 1'b0, VZero));
        q.push_back(mk(1'b1, OpAdd, 1'b0, VExAdd));
        q.push_back(mk(1'b1, OpAdd, 1'b0, VWbAlu));
        q.push_back(mk(1'b1, OpNor, 1'b0, VFetchRdy));
        q.push_back(mk(1'b1, OpNor, 1'b0, VZero));
        q.push_back(mk(1'b1, OpNor, 1'b0, VExNor));
        q.push_back(mk(1'b1, OpNor, 1'b0, VWbAlu));
        q.push_back(mk(1'b1, OpNoop, 1'b0, VFetchRdy));
        foreach (q[i]) begin
            next_cyc(q[i].rdy, q[i].opc, q[i].eq);
            checks++;
            if (strobes() !== q[i].exp) begin
                $display("FAIL alu_ops step %0d: got %b expected %b", i, strobes(), q[i].exp);
                failures++;
            end
        end
    endtask

    task automatic test_lw_wait_sw();
        vec_t q[$];
        do_reset();
        q.push_back(mk(1'b1, OpLw, 1'b0, VFetchRdy));
        q.push_back(mk(1'b1, OpLw, 1'b0, VZero));
        q.push_back(mk(1'b1, OpLw, 1'b0, VZero));
        q.push_back(mk(1'b0, OpLw, 1'b0, VMemLw));
        q.push_back(mk(1'b0, OpLw, 1'b0, VMemLw));
        q.push_back(mk(1'b0, OpLw, 1'b0, VMemLw));
        q.push_back(mk(1'b1, OpLw, 1'b0, VMemLw));
        q.push_back(mk(1'b1, OpLw, 1'b0, VWbLw));
        q.push_back(mk(1'b1, OpSw, 1'b0, VFetchRdy));
        q.push_back(mk(1'b1, OpSw, 1'b0, VZero));
        q.push_back(mk(1'b1, OpSw, 1'b0, VZero));
        q.push_back(mk(1'b1, OpSw, 1'b0, VMemSw));
        q.push_back(mk(1'b1, OpNoop, 1'b0, VFetchRdy));
        foreach (q[i]) begin
            next_cyc(q[i].rdy, q[i].opc, q[i].eq);
            checks++;
            if (strobes() !== q[i].exp) begin
                $display("FAIL lw_sw step %0d: got %b expected %b", i, strobes(), q[i].exp);
                failures++;
            end
        end
    endtask

    task automatic test_branch_jump();
        vec_t q[$];
        do_reset();
        q.push_back(mk(1'b1, OpBeq, 1'b0, VFetchRdy));
        q.push_back(mk(1'b1, OpBeq, 1'b0, VZero));
        q.push_back(mk(1'b1, OpBeq, 1'b1, VExBeqT));
        q.push_back(mk(1'b1, OpBeq, 1'b1, VFetchRdy));
        q.push_back(mk(1'b1, OpBeq, 1'b1, VZero));
        q.push_back(mk(1'b1, OpBeq, 1'b0, VExBeqF));
        q.push_back(mk(1'b1, OpJalr, 1'b0, VFetchRdy));
        q.push_back(mk(1'b1, OpJalr, 1'b0, VZero));
        q.push_back(mk(1'b1, OpJalr, 1'b1, VExJalr));
        q.push_back(mk(1'b1, OpNoop, 1'b0, VFetchRdy));
        q.push_back(mk(1'b1, OpNoop, 1'b0, VZero));
        q.push_back(mk(1'b0, OpNoop, 1'b0, VFetchW));
        foreach (q[i]) begin
            next_cyc(q[i].rdy, q[i].opc, q[i].eq);
            checks++;
            if (strobes() !== q[i].exp) begin
                $display("FAIL branch_jump step %0d: got %b expected %b", i, strobes(), q[i].exp);
                failures++;
            end
        end
    endtask

    task automatic test_watchdog();
        vec_t q[$];
        // 15 unanswered fetch cycles -> FAULT, absorbing even with ready high
        do_reset();
        for (int i = 0; i < 15; i++) q.push_back(mk(1'b0, OpAdd, 1'b0, VFetchW));
        for (int i = 0; i < 3; i++) q.push_back(mk(1'b1, OpAdd, 1'b0, VFault));
        foreach (q[i]) begin
            next_cyc(q[i].rdy, q[i].opc, q[i].eq);
            checks++;
            if (strobes() !== q[i].exp) begin
                $display("FAIL watchdog_fault step %0d: got %b expected %b", i, strobes(), q[i].exp);
                failures++;
            end
        end
        // Ready on the 15th cycle wins, in FETCH and then again in MEM
        q.delete();
        do_reset();
        for (int i = 0; i < 14; i++) q.push_back(mk(1'b0, OpLw, 1'b0, VFetchW));
        q.push_back(mk(1'b1, OpLw, 1'b0, VFetchRdy));
        q.push_back(mk(1'b0, OpLw, 1'b0, VZero));
        q.push_back(mk(1'b0, OpLw, 1'b0, VZero));
        for (int i = 0; i < 14; i++) q.push_back(mk(1'b0, OpLw, 1'b0, VMemLw));
        q.push_back(mk(1'b1, OpLw, 1'b0, VMemLw));
        q.push_back(mk(1'b0, OpLw, 1'b0, VWbLw));
        q.push_back(mk(1'b0, OpLw, 1'b0, VFetchW));
        foreach (q[i]) begin
            next_cyc(q[i].rdy, q[i].opc, q[i].eq);
            checks++;
            if (strobes() !== q[i].exp) begin
                $display("FAIL watchdog_edge step %0d: got %b expected %b", i, strobes(), q[i].exp);
                failures++;
            end
        end
    endtask

    task automatic test_halt_and_async_reset();
        vec_t q[$];
        do_reset();
        q.push_back(mk(1'b1, OpHalt, 1'b0, VFetchRdy));
        q.push_back(mk(1'b1, OpHalt, 1'b0, VZero));
        for (int i = 0; i < 20; i++) q.push_back(mk(1'b1, OpAdd, i[0], VHalted));
        foreach (q[i]) begin
            next_cyc(q[i].rdy, q[i].opc, q[i].eq);
            checks++;
            if (strobes() !== q[i].exp) begin
                $display("FAIL halt step %0d: got %b expected %b", i, strobes(), q[i].exp);
                failures++;
            end
        end
        // Asynchronous reset pulse mid-cycle
        rst_n = 1'b0;
        #1;
        checks++;
        if (strobes() !== VZero) begin
            $display("FAIL halt_async_reset: got %b expected %b", strobes(), VZero);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (strobes() !== VZero) begin
            $display("FAIL halt_idle: got %b expected %b", strobes(), VZero);
            failures++;
        end
        next_cyc(1'b0, OpNoop, 1'b0);
        checks++;
        if (strobes() !== VFetchW) begin
            $display("FAIL halt_refetch: got %b expected %b", strobes(), VFetchW);
            failures++;
        end
        // Reset while a load is waiting in MEM drops the request immediately
        q.delete();
        q.push_back(mk(1'b1, OpLw, 1'b0, VFetchRdy));
        q.push_back(mk(1'b1, OpLw, 1'b0, VZero));
        q.push_back(mk(1'b1, OpLw, 1'b0, VZero));
        q.push_back(mk(1'b0, OpLw, 1'b0, VMemLw));
        foreach (q[i]) begin
            next_cyc(q[i].rdy, q[i].opc, q[i].eq);
            checks++;
            if (strobes() !== q[i].exp) begin
                $display("FAIL mem_abort step %0d: got %b expected %b", i, strobes(), q[i].exp);
                failures++;
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.mem_req !== 1'b0) begin
            $display("FAIL mem_abort_req: got %b expected 0", bus_if.mem_req);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

`ifdef LC2K_PERF_CNT_EN
    task automatic test_perf();
        logic [2:0] prog [12];
        prog = '{OpAdd, OpAdd, OpAdd, OpAdd, OpSw, OpSw, OpSw, OpSw, OpNoop, OpNoop,
                 OpHalt, OpHalt};
        do_reset();
        checks++;
        if (bus_if.retired !== 0 || bus_if.cycles !== 0) begin
            $display("FAIL perf_reset: retired=%0d cycles=%0d expected 0 0",
                     bus_if.retired, bus_if.cycles);
            failures++;
        end
        for (int i = 0; i < 12; i++) next_cyc(1'b1, prog[i], 1'b0);
        next_cyc(1'b1, OpAdd, 1'b0);
        checks++;
        if (strobes() !== VHalted || bus_if.retired !== 4 || bus_if.cycles !== 12) begin
            $display("FAIL perf_at_halt: strobes=%b retired=%0d cycles=%0d expected %b 4 12",
                     strobes(), bus_if.retired, bus_if.cycles, VHalted);
            failures++;
        end
        for (int i = 0; i < 5; i++) next_cyc(1'b1, OpAdd, 1'b0);
        checks++;
        if (bus_if.retired !== 4 || bus_if.cycles !== 12) begin
            $display("FAIL perf_frozen: retired=%0d cycles=%0d expected 4 12",
                     bus_if.retired, bus_if.cycles);
            failures++;
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        test_reset();
        test_alu_ops();
        test_lw_wait_sw();
        test_branch_jump();
        test_watchdog();
        test_halt_and_async_reset();
`ifdef LC2K_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
